decoder_nx_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable, the successor to the fixed 3:8 combinational decoder. It adds valid/ready handshakes on input and output, a one-entry output register, and a self-running sweep mode that walks the one-hot output through every code at a programmable rate. It sits between a control/sequencer block and downstream select/strobe consumers, for example chip-selects or lamp and digit scanners.

---
 rtl/decoder_nx_seq.sv | 192 +++++++++++++++++++
 tb/tb_decoder_nx_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq
//   Registered N_IN-to-2**N_IN one-hot decoder with valid/ready handshakes
//   on both sides, a one-entry output register, and a self-running sweep
//   mode that walks the one-hot output through every code at a rate set
//   by SWEEP_DIV.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for en; mode selects DIRECT or SWEEP
//   S_DIRECT | decode accepted codes, one per cycle when not stalled
//   S_SWEEP  | prescaled walk of beats 0..W-1 through the output register
//   S_DONE   | sweep finished; parked until mode or en drops
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_en           block enable; low clears the outputs and aborts activity
//   i_mode         0 = direct decode, 1 = sweep (acted on only from S_IDLE)
//   i_in_valid     code valid
//   o_in_ready     code accepted when i_in_valid && o_in_ready
//   i_code         code to decode
//   o_out_valid    o_y / o_idx valid
//   i_out_ready    downstream accepts beat when o_out_valid && i_out_ready
//   o_y            one-hot decoded output, idle value when not valid
//   o_idx          binary index of the set bit in o_y
//   o_sweep_done   one-cycle pulse after the last sweep beat is accepted
//
// Build option:
//   DECODER_NX_ACTIVE_LOW_EN  defined: o_y is driven inverted (active-low,
//                             idle value all-ones). Undefined: active-high.

module decoder_nx_seq #(
    parameter int N_IN      = 3,
    parameter int SWEEP_DIV = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [N_IN-1:0]      i_code,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2**N_IN-1:0]   o_y,
    output logic [N_IN-1:0]      o_idx,
    output logic                 o_sweep_done
);

    localparam int              W          = 2**N_IN;
    localparam logic [N_IN-1:0] K_LAST     = '1;
    localparam logic [7:0]      PRESC_LAST = 8'(SWEEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SWEEP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [W-1:0]    r_y,          w_y_nxt;
    logic [N_IN-1:0] r_idx,        w_idx_nxt;
    logic            r_out_valid,  w_valid_nxt;
    logic            r_sweep_done, w_done_nxt;
    logic [7:0]      r_presc,      w_presc_nxt;
    logic [N_IN-1:0] r_k,          w_k_nxt;
    logic [N_IN-1:0] w_k_beat;
    logic            w_in_ready;
    logic            w_drain;

    assign w_drain = r_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_y          <= '0;
            r_idx        <= '0;
            r_out_valid  <= 1'b0;
            r_sweep_done <= 1'b0;
            r_presc      <= '0;
            r_k          <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_y          <= w_y_nxt;
            r_idx        <= w_idx_nxt;
            r_out_valid  <= w_valid_nxt;
            r_sweep_done <= w_done_nxt;
            r_presc      <= w_presc_nxt;
            r_k          <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_out_valid;
        w_done_nxt  = 1'b0;
        w_presc_nxt = r_presc;
        w_k_nxt     = r_k;
        w_k_beat    = r_k;
        w_in_ready  = 1'b0;

        if (!i_en) begin
            // Disable wins over any handshake: a pending beat is dropped.
            w_state_nxt = S_IDLE;
            w_y_nxt     = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_presc_nxt = '0;
            w_k_nxt     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_drain) begin
                        w_valid_nxt = 1'b0;
                        w_y_nxt     = '0;
                    end
                    if (!i_mode) begin
                        w_state_nxt = S_DIRECT;
                    end else if (!r_out_valid) begin
                        w_state_nxt = S_SWEEP;
                        w_presc_nxt = '0;
                        w_k_nxt     = '0;
                    end
                end
                S_DIRECT: begin
                    w_in_ready = !i_mode && (!r_out_valid || i_out_ready);
                    if (i_in_valid && w_in_ready) begin
                        w_y_nxt     = W'(1) << i_code;
                        w_idx_nxt   = i_code;
                        w_valid_nxt = 1'b1;
                    end else if (w_drain) begin
                        w_valid_nxt = 1'b0;
                        w_y_nxt     = '0;
                    end
                    if (i_mode && !r_out_valid) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SWEEP: begin
                    if (w_drain) begin
                        w_valid_nxt = 1'b0;
                        w_y_nxt     = '0;
                        if (r_k == K_LAST) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_k_beat = r_k + N_IN'(1);
                            w_k_nxt  = w_k_beat;
                        end
                    end
                    // The accept cycle counts as the first prescaler tick, so
                    // unstalled beats are exactly SWEEP_DIV cycles apart.
                    if (w_state_nxt == S_SWEEP && (!r_out_valid || i_out_ready)) begin
                        if (r_presc >= PRESC_LAST) begin
                            w_y_nxt     = W'(1) << w_k_beat;
                            w_idx_nxt   = w_k_beat;
                            w_valid_nxt = 1'b1;
                            w_presc_nxt = '0;
                        end else begin
                            w_presc_nxt = r_presc + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    w_valid_nxt = 1'b0;
                    w_y_nxt     = '0;
                    if (!i_mode) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_idx        = r_idx;
    assign o_sweep_done = r_sweep_done;

`ifdef DECODER_NX_ACTIVE_LOW_EN
    assign o_y = ~r_y;
`else
    assign o_y = r_y;
`endif

endmodule

// File: tb/tb_decoder_nx_seq.sv
module tb_decoder_nx_seq;

    localparam int N_IN      = 3;
    localparam int W         = 8;
    localparam int SWEEP_DIV = 4;

`ifdef DECODER_NX_ACTIVE_LOW_EN
    localparam logic [W-1:0] Y_IDLE = '1;
`else
    localparam logic [W-1:0] Y_IDLE = '0;
`endif

    typedef struct packed {
        logic [W-1:0]    y;
        logic [N_IN-1:0] idx;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst, en, mode, in_valid, in_ready;
    logic            out_valid, out_ready, sweep_done;
    logic [N_IN-1:0] code, idx;
    logic [W-1:0]    y;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    n_beats  = 0;
    int    n_done   = 0;
    int    last_beat_cyc = 0;
    int    exp_gap  = 0;
    bit    gap_armed = 1'b0;
    int    base;
    beat_t sb[$];
    beat_t mon_exp;

    decoder_nx_seq #(.N_IN(N_IN), .SWEEP_DIV(SWEEP_DIV)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_code       (code),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_y          (y),
        .o_idx        (idx),
        .o_sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic beat_t mk(input int k);
        beat_t b;
        b.y   = (W'(1) << k) ^ Y_IDLE;
        b.idx = N_IN'(k);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int k = 0; k < W; k++) sb.push_back(mk(k));
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) step();
        chk(tag, n_done, target);
    endtask

    // Scoreboard: accepted codes are pushed; delivered beats are popped.
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) chk("idle_y", y, Y_IDLE);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", sb.size(), 1);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("beat_y", y, mon_exp.y);
                    chk("beat_idx", idx, mon_exp.idx);
                end
                if (gap_armed && exp_gap != 0) chk("beat_gap", cyc - last_beat_cyc, exp_gap);
                gap_armed     = 1'b1;
                last_beat_cyc = cyc;
                n_beats++;
            end
            if (in_valid && in_ready) sb.push_back(mk(int'(code)));
            if (sweep_done) n_done++;
        end
    end

    initial begin
        // Reset has priority over an active input.
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1; code = 3'd5; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_y", y, Y_IDLE);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_idx", idx, 0);
        chk("rst_done", sweep_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready_idle", in_ready, 0);
        step();
        @(negedge clk);
        chk("rel_ready_direct", in_ready, 1);
        step();

        // Direct decode, one code per cycle.
        exp_gap = 1; gap_armed = 1'b0; base = n_beats;
        for (int k = 0; k < W; k++) begin
            in_valid = 1'b1; code = N_IN'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        exp_gap = 0;
        chk("direct_beats", n_beats - base, W);
        chk("direct_sb_empty", sb.size(), 0);

        // Backpressure.
        out_ready = 1'b0; in_valid = 1'b1; code = 3'd6;
        step();
        code = 3'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_y", y, mk(6).y);
            chk("stall_idx", idx, 6);
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_y", y, mk(2).y);
        step();
        step();
        chk("bp_sb_empty", sb.size(), 0);

        // Sweep with no backpressure.
        mode = 1'b1; exp_gap = SWEEP_DIV; gap_armed = 1'b0; base = n_beats;
        push_sweep();
        wait_done("sweep1_done_seen", 1, 200);
        for (int i = 0; i < 10; i++) step();
        chk("sweep1_done_pulses", n_done, 1);
        chk("sweep1_beats", n_beats - base, W);
        chk("sweep1_sb_empty", sb.size(), 0);
        chk("sweep1_no_restart", out_valid, 0);

        // Restart via mode toggle, then abort on a stalled beat.
        mode = 1'b0;
        step();
        mode = 1'b1; gap_armed = 1'b0; base = n_beats;
        push_sweep();
        for (int i = 0; i < 100 && (n_beats - base) < 3; i++) step();
        chk("restart_beats", n_beats - base, 3);
        out_ready = 1'b0; exp_gap = 0;
        for (int i = 0; i < 50 && !out_valid; i++) step();
        @(negedge clk);
        chk("abort_pre_valid", out_valid, 1);
        chk("abort_pre_y", y, mk(3).y);
        @(posedge clk);
        #1;
        en = 1'b0;
        step();
        @(negedge clk);
        chk("abort_y", y, Y_IDLE);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        en = 1'b1; out_ready = 1'b1; exp_gap = SWEEP_DIV; gap_armed = 1'b0; base = n_beats;
        push_sweep();
        wait_done("sweep2_done_seen", 2, 200);
        step();
        step();
        chk("sweep2_beats", n_beats - base, W);
        chk("sweep2_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
